// File: rtl/kernel_stream_shell_pkg.sv
// Shared definitions for the kernel stream shell.
//   FPC_EF_W      : width of the FloPoCo exception field
//   FPC_EF_NORMAL : exception code for a "normal" number
//   kw()          : kernel-side word width for a given stream width
// Build option: FPC_EF_EN (when defined, kernel words carry the 2-bit
// exception field above each stream word).
package kernel_shell_pkg;

   localparam int FPC_EF_W = 2;
   localparam logic [FPC_EF_W-1:0] FPC_EF_NORMAL = 2'b01;

   function automatic int kw(input int streamw);
`ifdef FPC_EF_EN
      return streamw + FPC_EF_W;
`else
      return streamw;
`endif
   endfunction

endpackage

// File: rtl/kernel_stream_shell_if.sv
// Bundle of all stream and kernel handshake signals around the shell.
//   in_data/in_valid/in_ready     : NIN input streams (word i at [i*STREAMW +: STREAMW])
//   out_data/out_valid/out_ready  : NOUT output streams
//   k_data_in/k_ivalid/k_iready   : joined beat towards the kernel
//   k_data_out/k_ovalid/k_oready  : kernel result beat
//   beat_count                    : kernel results accepted since reset
// Modports: master = environment/kernel side, slave = shell side.
// Build option: FPC_EF_EN widens the kernel words (see kernel_shell_pkg).
interface kernel_stream_shell_if #(
   parameter int STREAMW = 32,
   parameter int NIN     = 4,
   parameter int NOUT    = 4
);
   import kernel_shell_pkg::*;

   localparam int KW = kw(STREAMW);

   logic [NIN*STREAMW-1:0]  in_data;
   logic [NIN-1:0]          in_valid;
   logic [NIN-1:0]          in_ready;
   logic [NOUT*STREAMW-1:0] out_data;
   logic [NOUT-1:0]         out_valid;
   logic [NOUT-1:0]         out_ready;
   logic [NIN*KW-1:0]       k_data_in;
   logic                    k_ivalid;
   logic                    k_iready;
   logic [NOUT*KW-1:0]      k_data_out;
   logic                    k_ovalid;
   logic                    k_oready;
   logic [31:0]             beat_count;

   modport master (
      output in_data, in_valid, out_ready, k_iready, k_data_out, k_ovalid,
      input  in_ready, out_data, out_valid, k_data_in, k_ivalid, k_oready, beat_count
   );

   modport slave (
      input  in_data, in_valid, out_ready, k_iready, k_data_out, k_ovalid,
      output in_ready, out_data, out_valid, k_data_in, k_ivalid, k_oready, beat_count
   );

endinterface

// File: rtl/kernel_stream_shell_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write request and word; ignored while full (no write-through)
//   pop/dout : read request and head word; pop ignored while empty
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module stream_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // Full is judged on the registered count only, so a pop in the same
   // cycle never opens room for a push.
   always_comb begin
      full    = (count == FULL_CNT);
      empty   = (count == '0);
      do_push = push & ~full;
      do_pop  = pop & ~empty;
      dout    = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the pointers decide what is visible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/kernel_stream_shell.sv
// kernel_stream_shell: joins NIN input streams into one kernel beat and
// forks kernel results into NOUT independently drained output streams.
//   clk  : system clock
//   rst  : synchronous active-high reset; clears all FIFOs and beat_count,
//          and holds in_ready/out_valid/k_ivalid/k_oready low while high
//   bus  : kernel_stream_shell_if slave modport (all stream/kernel signals)
// Parameters: STREAMW word width, NIN/NOUT channel counts, DEPTH FIFO depth.
// Build option: FPC_EF_EN -- kernel words are {2'b01, word} towards the
// kernel; the top 2 bits of each kernel result word are dropped.
module kernel_stream_shell
   import kernel_shell_pkg::*;
#(
   parameter int STREAMW = 32,
   parameter int NIN     = 4,
   parameter int NOUT    = 4,
   parameter int DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   kernel_stream_shell_if.slave bus
);

   localparam int KW = kw(STREAMW);

   logic [NIN-1:0]          in_full;
   logic [NIN-1:0]          in_empty;
   logic [NIN-1:0]          in_ready_w;
   logic [NIN*STREAMW-1:0]  in_head;
   logic                    k_ivalid_w;
   logic                    in_pop;
   logic [NIN*KW-1:0]       k_data_in_w;

   logic [NOUT-1:0]         out_full;
   logic [NOUT-1:0]         out_empty;
   logic [NOUT-1:0]         out_valid_w;
   logic [NOUT*STREAMW-1:0] out_head;
   logic [NOUT*STREAMW-1:0] out_din;
   logic                    k_oready_w;
   logic                    out_push;
   logic [31:0]             beat_count_r;

   // ---------------- input side: per-channel FIFOs and join ----------------
   always_comb begin
      in_ready_w = rst ? '0 : ~in_full;
      k_ivalid_w = ~rst & (&(~in_empty));
      in_pop     = k_ivalid_w & bus.k_iready;
   end

   for (genvar i = 0; i < NIN; i++) begin : g_in
      stream_fifo #(
         .W     (STREAMW),
         .DEPTH (DEPTH)
      ) u_in_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (bus.in_valid[i] & in_ready_w[i]),
         .din   (bus.in_data[i*STREAMW +: STREAMW]),
         .pop   (in_pop),
         .dout  (in_head[i*STREAMW +: STREAMW]),
         .full  (in_full[i]),
         .empty (in_empty[i])
      );
   end

   always_comb begin
      k_data_in_w = '0;
      for (int unsigned i = 0; i < NIN; i++) begin
`ifdef FPC_EF_EN
         k_data_in_w[i*KW +: KW] = {FPC_EF_NORMAL, in_head[i*STREAMW +: STREAMW]};
`else
         k_data_in_w[i*KW +: KW] = in_head[i*STREAMW +: STREAMW];
`endif
      end
   end

   // ---------------- output side: fork into per-channel FIFOs ----------------
   always_comb begin
      k_oready_w  = ~rst & (&(~out_full));
      out_push    = bus.k_ovalid & k_oready_w;
      out_valid_w = rst ? '0 : ~out_empty;
   end

   // Only the low STREAMW bits of each kernel slice are stored; with the
   // exception field enabled this discards the top FPC_EF_W bits.
   always_comb begin
      out_din = '0;
      for (int unsigned j = 0; j < NOUT; j++) begin
         out_din[j*STREAMW +: STREAMW] = bus.k_data_out[j*KW +: STREAMW];
      end
   end

   for (genvar j = 0; j < NOUT; j++) begin : g_out
      stream_fifo #(
         .W     (STREAMW),
         .DEPTH (DEPTH)
      ) u_out_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (out_push),
         .din   (out_din[j*STREAMW +: STREAMW]),
         .pop   (bus.out_ready[j] & out_valid_w[j]),
         .dout  (out_head[j*STREAMW +: STREAMW]),
         .full  (out_full[j]),
         .empty (out_empty[j])
      );
   end

   // Free-running 32-bit counter of accepted kernel results; wraps to 0.
   always_ff @(posedge clk) begin
      if (rst)           beat_count_r <= '0;
      else if (out_push) beat_count_r <= beat_count_r + 32'd1;
   end

   // ---------------- interface outputs ----------------
   always_comb begin
      bus.in_ready   = in_ready_w;
      bus.k_ivalid   = k_ivalid_w;
      bus.k_data_in  = k_data_in_w;
      bus.k_oready   = k_oready_w;
      bus.out_valid  = out_valid_w;
      bus.out_data   = out_head;
      bus.beat_count = beat_count_r;
   end

endmodule

// File: tb/tb_kernel_stream_shell.sv
// Directed testbench for kernel_stream_shell (NIN=NOUT=4, DEPTH=4, 32-bit).
// The bench plays both the stream environment and the kernel.
// Build option: FPC_EF_EN selects the exception-field variant.
module tb_kernel_stream_shell;
   import kernel_shell_pkg::*;

   localparam int SW    = 32;
   localparam int NIN   = 4;
   localparam int NOUT  = 4;
   localparam int DEPTH = 4;
   localparam int KW    = kw(SW);

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   kernel_stream_shell_if #(.STREAMW(SW), .NIN(NIN), .NOUT(NOUT)) bus ();

   kernel_stream_shell #(
      .STREAMW (SW),
      .NIN     (NIN),
      .NOUT    (NOUT),
      .DEPTH   (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected kernel input for a given set of stream words.
   function automatic logic [NIN*KW-1:0] exp_kin(input logic [NIN*SW-1:0] w);
      logic [NIN*KW-1:0] r;
      r = '0;
      for (int i = 0; i < NIN; i++) begin
         r[i*KW +: SW] = w[i*SW +: SW];
`ifdef FPC_EF_EN
         r[i*KW+SW +: 2] = 2'b01;
`endif
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] beat_word(input int j, input int b);
      return {8'(8'hA0 + j), 24'(b)};
   endfunction

   // Kernel result beat b; exception bits (if any) set to 2'b10 so that
   // dropping them is observable.
   function automatic logic [NOUT*KW-1:0] build_kout(input int b);
      logic [NOUT*KW-1:0] r;
      r = '0;
      for (int j = 0; j < NOUT; j++) begin
         r[j*KW +: SW] = beat_word(j, b);
`ifdef FPC_EF_EN
         r[j*KW+SW +: 2] = 2'b10;
`endif
      end
      return r;
   endfunction

   function automatic logic [NIN*SW-1:0] full_words(input int n);
      logic [NIN*SW-1:0] r;
      for (int i = 0; i < NIN; i++) r[i*SW +: SW] = {16'(16'hC000 + i), 16'(n)};
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b want 0000", bus.in_ready); end
      checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL rst_out_valid: got %b want 0000", bus.out_valid); end
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL rst_k_ivalid: got %b want 0", bus.k_ivalid); end
      checks++; if (bus.k_oready !== 1'b0) begin errors++; $display("FAIL rst_k_oready: got %b want 0", bus.k_oready); end
      checks++; if (bus.beat_count !== 32'd0) begin errors++; $display("FAIL rst_beat_count: got %0d want 0", bus.beat_count); end
      rst = 1'b0;
      tick();
      checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL idle_in_ready: got %b want 1111", bus.in_ready); end
      checks++; if (bus.k_oready !== 1'b1) begin errors++; $display("FAIL idle_k_oready: got %b want 1", bus.k_oready); end
      checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL idle_out_valid: got %b want 0000", bus.out_valid); end
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL idle_k_ivalid: got %b want 0", bus.k_ivalid); end
      checks++; if (bus.beat_count !== 32'd0) begin errors++; $display("FAIL idle_beat_count: got %0d want 0", bus.beat_count); end
   endtask

   task automatic test_join();
      logic [NIN*SW-1:0] w;
      w = {4{32'h3F800000}};
      bus.in_data  = w;
      bus.in_valid = 4'b0111;
      tick();
      bus.in_valid = 4'b0000;
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL join_partial: got %b want 0", bus.k_ivalid); end
      tick();
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL join_partial_hold: got %b want 0", bus.k_ivalid); end
      bus.in_valid = 4'b1000;
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL join_latency: got %b want 0", bus.k_ivalid); end
      tick();
      bus.in_valid = 4'b0000;
      checks++; if (bus.k_ivalid !== 1'b1) begin errors++; $display("FAIL join_complete: got %b want 1", bus.k_ivalid); end
      checks++; if (bus.k_data_in !== exp_kin(w)) begin errors++; $display("FAIL join_data: got %h want %h", bus.k_data_in, exp_kin(w)); end
      bus.k_iready = 1'b1;
      tick();
      bus.k_iready = 1'b0;
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL join_popped: got %b want 0", bus.k_ivalid); end
      checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL join_in_ready: got %b want 1111", bus.in_ready); end
   endtask

   task automatic test_fork_backpressure();
      int fed;
      int got [NOUT];
      fed = 0;
      for (int j = 0; j < NOUT; j++) got[j] = 0;
      bus.out_ready = 4'b1101;
      for (int c = 0; c < 24; c++) begin
         if (c == 8) begin
            checks++; if (bus.k_oready !== 1'b0) begin errors++; $display("FAIL fork_k_oready_full: got %b want 0", bus.k_oready); end
            checks++; if (bus.beat_count !== 32'd4) begin errors++; $display("FAIL fork_count_stalled: got %0d want 4", bus.beat_count); end
            checks++; if (got[1] !== 0) begin errors++; $display("FAIL fork_ch1_stalled: got %0d want 0", got[1]); end
            for (int j = 0; j < NOUT; j++) if (j != 1) begin
               checks++; if (got[j] !== 4) begin errors++; $display("FAIL fork_other_ch%0d: got %0d want 4", j, got[j]); end
            end
            bus.out_ready = 4'b1111;
         end
         for (int j = 0; j < NOUT; j++) begin
            if (bus.out_valid[j] && bus.out_ready[j]) begin
               checks++;
               if (bus.out_data[j*SW +: SW] !== beat_word(j, got[j] + 1)) begin
                  errors++;
                  $display("FAIL fork_data_ch%0d: got %h want %h", j, bus.out_data[j*SW +: SW], beat_word(j, got[j] + 1));
               end
               got[j]++;
            end
         end
         if (fed < 5) begin
            bus.k_ovalid   = 1'b1;
            bus.k_data_out = build_kout(fed + 1);
            if (bus.k_oready) fed++;
         end else begin
            bus.k_ovalid = 1'b0;
         end
         tick();
      end
      bus.k_ovalid = 1'b0;
      for (int j = 0; j < NOUT; j++) begin
         checks++; if (got[j] !== 5) begin errors++; $display("FAIL fork_total_ch%0d: got %0d want 5", j, got[j]); end
      end
      checks++; if (bus.beat_count !== 32'd5) begin errors++; $display("FAIL fork_count: got %0d want 5", bus.beat_count); end
      checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL fork_drained: got %b want 0000", bus.out_valid); end
      checks++; if (bus.k_oready !== 1'b1) begin errors++; $display("FAIL fork_k_oready_back: got %b want 1", bus.k_oready); end
   endtask

   task automatic test_input_full();
      bus.k_iready = 1'b0;
      for (int n = 1; n <= DEPTH; n++) begin
         bus.in_valid = 4'b1111;
         bus.in_data  = full_words(n);
         tick();
      end
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL full_in_ready: got %b want 0000", bus.in_ready); end
      checks++; if (bus.k_ivalid !== 1'b1) begin errors++; $display("FAIL full_k_ivalid: got %b want 1", bus.k_ivalid); end
      bus.in_data = full_words(5);
      tick();
      checks++; if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL full_refused: got %b want 0000", bus.in_ready); end
      // Pop while the 5th word is still offered: it must not slip in.
      bus.k_iready = 1'b1;
      tick();
      bus.k_iready = 1'b0;
      bus.in_valid = 4'b0000;
      checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL full_one_pop_ready: got %b want 1111", bus.in_ready); end
      for (int n = 2; n <= DEPTH; n++) begin
         checks++; if (bus.k_ivalid !== 1'b1) begin errors++; $display("FAIL full_drain_valid_%0d: got %b want 1", n, bus.k_ivalid); end
         checks++; if (bus.k_data_in !== exp_kin(full_words(n))) begin errors++; $display("FAIL full_drain_data_%0d: got %h want %h", n, bus.k_data_in, exp_kin(full_words(n))); end
         bus.k_iready = 1'b1;
         tick();
         bus.k_iready = 1'b0;
      end
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL full_no_fifth: got %b want 0", bus.k_ivalid); end
   endtask

   task automatic test_ef_field();
      logic [KW-1:0]      want_k;
      logic [NOUT*KW-1:0] ko;
      logic [SW-1:0]      want_o;
`ifdef FPC_EF_EN
      want_k = 34'h1_40490FDB;
`else
      want_k = 32'h40490FDB;
`endif
      bus.in_data  = {4{32'h40490FDB}};
      bus.in_valid = 4'b1111;
      tick();
      bus.in_valid = 4'b0000;
      checks++; if (bus.k_data_in[KW-1:0] !== want_k) begin errors++; $display("FAIL ef_k_data_in: got %h want %h", bus.k_data_in[KW-1:0], want_k); end
      bus.k_iready = 1'b1;
      tick();
      bus.k_iready = 1'b0;
      ko = '0;
      for (int j = 0; j < NOUT; j++) begin
         ko[j*KW +: SW] = (j == 0) ? 32'h1 : 32'(32'h100 + j);
`ifdef FPC_EF_EN
         ko[j*KW+SW +: 2] = 2'b10;
`endif
      end
      bus.out_ready  = 4'b0000;
      bus.k_data_out = ko;
      bus.k_ovalid   = 1'b1;
      tick();
      bus.k_ovalid   = 1'b0;
      bus.k_data_out = '0;
      tick();
      checks++; if (bus.out_valid !== 4'b1111) begin errors++; $display("FAIL ef_out_valid: got %b want 1111", bus.out_valid); end
      for (int j = 0; j < NOUT; j++) begin
         want_o = (j == 0) ? 32'h1 : 32'(32'h100 + j);
         checks++; if (bus.out_data[j*SW +: SW] !== want_o) begin errors++; $display("FAIL ef_out_data_ch%0d: got %h want %h", j, bus.out_data[j*SW +: SW], want_o); end
      end
      checks++; if (bus.beat_count !== 32'd6) begin errors++; $display("FAIL ef_beat_count: got %0d want 6", bus.beat_count); end
      bus.out_ready = 4'b1111;
      tick();
      checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL ef_drained: got %b want 0000", bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 4'b0000;
      bus.k_iready  = 1'b0;
      for (int b = 1; b <= 3; b++) begin
         bus.k_ovalid   = 1'b1;
         bus.k_data_out = build_kout(10 + b);
         bus.in_valid   = 4'b1111;
         bus.in_data    = full_words(20 + b);
         tick();
      end
      bus.k_ovalid = 1'b0;
      bus.in_valid = 4'b0000;
      checks++; if (bus.out_valid !== 4'b1111) begin errors++; $display("FAIL mid_buffered: got %b want 1111", bus.out_valid); end
      checks++; if (bus.beat_count !== 32'd9) begin errors++; $display("FAIL mid_count_pre: got %0d want 9", bus.beat_count); end
      rst = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_out_valid: got %b want 0000", bus.out_valid); end
      checks++; if (bus.beat_count !== 32'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", bus.beat_count); end
      checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL mid_rst_k_ivalid: got %b want 0", bus.k_ivalid); end
      rst = 1'b0;
      bus.out_ready = 4'b1111;
      bus.k_iready  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("FAIL mid_stale_out_%0d: got %b want 0000", c, bus.out_valid); end
         checks++; if (bus.k_ivalid !== 1'b0) begin errors++; $display("FAIL mid_stale_kin_%0d: got %b want 0", c, bus.k_ivalid); end
         tick();
      end
      bus.k_iready = 1'b0;
      checks++; if (bus.beat_count !== 32'd0) begin errors++; $display("FAIL mid_count_post: got %0d want 0", bus.beat_count); end
      checks++; if (bus.in_ready !== 4'b1111) begin errors++; $display("FAIL mid_in_ready: got %b want 1111", bus.in_ready); end
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst            = 1'b1;
      bus.in_data    = '0;
      bus.in_valid   = '0;
      bus.out_ready  = '0;
      bus.k_iready   = 1'b0;
      bus.k_data_out = '0;
      bus.k_ovalid   = 1'b0;
      test_reset();
      test_join();
      test_fork_backpressure();
      test_input_full();
      test_ef_field();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
